alu_op_issue: RTL and testbench

//  Issue stage that drives the ALU's operation/operand interface. Decodes ALUOp/funct3/funct7[5]

---
 rtl/alu_op_issue.sv | 157 +++++++++++++++
 tb/tb_alu_op_issue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// ALU issue stage: decodes ALUOp/funct3/funct7[5] into a 4-bit ALU code and queues it with its operands
// in a 2-entry skid buffer. Optional encodings (NOR, EQ) are enabled by defining ALU_OP_EXT_EN.
module alu_op_issue #(
  parameter int          WIDTH      = 32,
  parameter int          CNT_W      = 8,
  parameter logic [3:0]  ILLEGAL_OP = 4'b0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ALU_Operation,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ill;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     r_state, w_state_nxt;
  entry_t     r_head, r_skid, w_new;
  logic       r_in_ready;
  logic [CNT_W-1:0] r_cnt;
  logic       w_accept, w_xfer;
  logic       w_load_head, w_head_from_skid, w_load_skid;
  logic [3:0] w_op;
  logic       w_ill;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_op  = ILLEGAL_OP;
    w_ill = 1'b1;
    case (ALUOp)
      2'b00: begin w_op = 4'b0010; w_ill = 1'b0; end
      2'b01: begin
        if (funct3 == 3'b001) begin
`ifdef ALU_OP_EXT_EN
          w_op  = 4'b1111;
          w_ill = 1'b0;
`endif
        end else begin
          w_op  = 4'b0110;
          w_ill = 1'b0;
        end
      end
      2'b10: begin
        case (funct3)
          3'b000: begin w_op = funct7_5 ? 4'b0110 : 4'b0010; w_ill = 1'b0; end
          3'b111: begin w_op = 4'b0000; w_ill = 1'b0; end
          3'b110: begin w_op = 4'b0001; w_ill = 1'b0; end
          3'b010: begin w_op = 4'b0111; w_ill = 1'b0; end
`ifdef ALU_OP_EXT_EN
          3'b100: if (funct7_5) begin w_op = 4'b1100; w_ill = 1'b0; end
`endif
          default: ;
        endcase
      end
      default: begin
        // I-type ignores funct7_5: there is no register-immediate subtract.
        case (funct3)
          3'b000: begin w_op = 4'b0010; w_ill = 1'b0; end
          3'b111: begin w_op = 4'b0000; w_ill = 1'b0; end
          3'b110: begin w_op = 4'b0001; w_ill = 1'b0; end
          3'b010: begin w_op = 4'b0111; w_ill = 1'b0; end
          default: ;
        endcase
      end
    endcase
  end

  assign w_new    = '{op: w_op, a: a_in, b: b_in, ill: w_ill};
  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = (r_state != EMPTY) & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_head_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: if (w_accept) begin
        w_state_nxt = ONE;
        w_load_head = 1'b1;
      end
      ONE: begin
        if (w_accept && !w_xfer) begin
          w_state_nxt = TWO;
          w_load_skid = 1'b1;
        end else if (w_xfer && !w_accept) begin
          w_state_nxt = EMPTY;
        end else if (w_accept && w_xfer) begin
          w_load_head = 1'b1;
        end
      end
      TWO: if (w_xfer) begin
        w_state_nxt      = ONE;
        w_head_from_skid = 1'b1;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
      if (w_accept && w_ill && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_head <= '0;
    else if (w_load_head)
      r_head <= w_new;
    else if (w_head_from_skid)
      r_head <= r_skid;
  end

  // NOTE: the skid entry is data-only storage qualified by r_state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_load_skid)
      r_skid <= w_new;
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = (r_state != EMPTY);
  assign ALU_Operation = r_head.op;
  assign a             = r_head.a;
  assign b             = r_head.b;
  assign illegal       = r_head.ill;
  assign illegal_cnt   = r_cnt;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: a queue-based model of the two-entry buffer is compared against the
// DUT every cycle on the falling edge; expected decodes are written by hand per stimulus step.
module tb_alu_op_issue;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, funct7_5, out_valid, out_ready, illegal;
  logic [1:0]       ALUOp;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a_in, b_in, a, b;
  logic [3:0]       ALU_Operation;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  alu_op_issue #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ILLEGAL_OP(4'b0010)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_Operation(ALU_Operation),
    .a(a), .b(b), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ill;
  } exp_t;

  typedef struct {
    logic [1:0] aluop;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] op;
    logic       ill;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  bit   chk_en = 1'b0;
  bit   acc_flag;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT against the model, then advance the model across the next rising edge.
  task automatic cycle();
    bit acc, xfer;
    @(negedge clk);
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      check("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
      if (sb.size() > 0) begin
        check("alu_op", 64'(ALU_Operation), 64'(sb[0].op));
        check("a", 64'(a), 64'(sb[0].a));
        check("b", 64'(b), 64'(sb[0].b));
        check("illegal", 64'(illegal), 64'(sb[0].ill));
      end
    end
    acc      = in_valid && (sb.size() < 2);
    xfer     = out_ready && (sb.size() > 0);
    acc_flag = acc && !reset;
    if (reset) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (xfer) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(cur);
        if (cur.ill && exp_cnt < 255) exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op2, input logic [2:0] f3, input logic f7,
                       input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [3:0] eop, input logic eill);
    in_valid = 1'b1;
    ALUOp    = op2;
    funct3   = f3;
    funct7_5 = f7;
    a_in     = av;
    b_in     = bv;
    cur      = '{op: eop, a: av, b: bv, ill: eill};
  endtask

  task automatic send(input logic [1:0] op2, input logic [2:0] f3, input logic f7,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic [3:0] eop, input logic eill, input bit rand_rdy);
    drive(op2, f3, f7, av, bv, eop, eill);
    acc_flag = 1'b0;
    for (int i = 0; i < 40 && !acc_flag; i++) begin
      if (rand_rdy) out_ready = (i >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle();
    end
    if (!acc_flag) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout observed=no_accept expected=accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) cycle();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout observed=%0d expected=0", sb.size());
    end
    cycle();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; a_in = '0; b_in = '0;
    cur = '{op: 4'd0, a: '0, b: '0, ill: 1'b0};
    cycle();
    cycle();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset values
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alu_op", 64'(ALU_Operation), 64'd0);
    check("rst_a", 64'(a), 64'd0);
    check("rst_b", 64'(b), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_cnt", 64'(illegal_cnt), 64'd0);

    // T1: SUB with 1-cycle latency
    out_ready = 1'b1;
    send(2'b10, 3'b000, 1'b1, 32'd5, 32'd3, 4'b0110, 1'b0, 1'b0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_op", 64'(ALU_Operation), 64'h6);
    check("t1_a", 64'(a), 64'd5);
    check("t1_b", 64'(b), 64'd3);
    drain();

    // T2: fill both entries, third bundle held until the ALU drains
    out_ready = 1'b0;
    send(2'b10, 3'b111, 1'b0, 32'd1, 32'd11, 4'b0000, 1'b0, 1'b0);
    send(2'b10, 3'b110, 1'b0, 32'd2, 32'd22, 4'b0001, 1'b0, 1'b0);
    check("t2_full_in_ready", 64'(in_ready), 64'd0);
    drive(2'b10, 3'b010, 1'b0, 32'd3, 32'd33, 4'b0111, 1'b0);
    cycle();
    cycle();
    check("t2_held_a", 64'(a), 64'd1);
    out_ready = 1'b1;
    send(2'b10, 3'b010, 1'b0, 32'd3, 32'd33, 4'b0111, 1'b0, 1'b0);
    drain();

    // T3: illegal encoding, then saturation of the counter
    send(2'b10, 3'b101, 1'b0, 32'd7, 32'd8, 4'b0010, 1'b1, 1'b0);
    drain();
    check("t3_cnt_one", 64'(illegal_cnt), 64'd1);
    for (int i = 0; i < 300; i++)
      send(2'b11, 3'(i % 2 ? 3'b001 : 3'b101), 1'b0, 32'(i), 32'(~i), 4'b0010, 1'b1, 1'b0);
    drain();
    check("t3_cnt_sat", 64'(illegal_cnt), 64'd255);

    // T4/T6: decode table under random back-pressure
    tbl.push_back('{aluop: 2'b11, f3: 3'b000, f7: 1'b1, op: 4'b0010, ill: 1'b0});
    tbl.push_back('{aluop: 2'b01, f3: 3'b000, f7: 1'b0, op: 4'b0110, ill: 1'b0});
    tbl.push_back('{aluop: 2'b01, f3: 3'b111, f7: 1'b1, op: 4'b0110, ill: 1'b0});
    tbl.push_back('{aluop: 2'b00, f3: 3'b101, f7: 1'b1, op: 4'b0010, ill: 1'b0});
    tbl.push_back('{aluop: 2'b10, f3: 3'b000, f7: 1'b0, op: 4'b0010, ill: 1'b0});
    tbl.push_back('{aluop: 2'b11, f3: 3'b111, f7: 1'b0, op: 4'b0000, ill: 1'b0});
    tbl.push_back('{aluop: 2'b11, f3: 3'b110, f7: 1'b1, op: 4'b0001, ill: 1'b0});
    tbl.push_back('{aluop: 2'b11, f3: 3'b010, f7: 1'b0, op: 4'b0111, ill: 1'b0});
    tbl.push_back('{aluop: 2'b10, f3: 3'b100, f7: 1'b0, op: 4'b0010, ill: 1'b1});
`ifdef ALU_OP_EXT_EN
    tbl.push_back('{aluop: 2'b10, f3: 3'b100, f7: 1'b1, op: 4'b1100, ill: 1'b0});
    tbl.push_back('{aluop: 2'b01, f3: 3'b001, f7: 1'b0, op: 4'b1111, ill: 1'b0});
`else
    tbl.push_back('{aluop: 2'b10, f3: 3'b100, f7: 1'b1, op: 4'b0010, ill: 1'b1});
    tbl.push_back('{aluop: 2'b01, f3: 3'b001, f7: 1'b0, op: 4'b0010, ill: 1'b1});
`endif
    for (int r = 0; r < 3; r++)
      foreach (tbl[k])
        send(tbl[k].aluop, tbl[k].f3, tbl[k].f7, $urandom, $urandom, tbl[k].op, tbl[k].ill, 1'b1);
    drain();

    // T5: reset while both entries are held
    out_ready = 1'b0;
    send(2'b10, 3'b101, 1'b0, 32'd9, 32'd9, 4'b0010, 1'b1, 1'b0);
    send(2'b00, 3'b000, 1'b0, 32'd4, 32'd4, 4'b0010, 1'b0, 1'b0);
    check("t5_two_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_cnt", 64'(illegal_cnt), 64'd0);
    out_ready = 1'b1;
    send(2'b10, 3'b000, 1'b0, 32'd12, 32'd13, 4'b0010, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
